// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM load sequencer slice.
//   seq_state_t  - sequencer FSM states (IDLE, LOAD)
//   DEF_DWIDTH   - default duty value width
//   DEF_STAGE    - default number of PWM channels
//   LOAD_CNT_W   - width of the completed-burst counter
package pwm_pkg;

  typedef enum logic {
    IDLE,
    LOAD
  } seq_state_t;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_STAGE  = 8;
  localparam int LOAD_CNT_W = 8;

endpackage

// File: rtl/pwm_load_sequencer_if.sv
// pwm_load_sequencer_if: host-side and PWM-array-side signals of the load
// sequencer.
//   master: drives enable, wr_en, wr_addr, wr_data, commit; observes the rest
//   slave : the sequencer; drives pwm_start, pwm_data, boundary, busy,
//           pending, load_count
interface pwm_load_sequencer_if
  import pwm_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int STAGE  = DEF_STAGE
);

  localparam int AW = (STAGE > 1) ? $clog2(STAGE) : 1;

  logic                  enable;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DWIDTH-1:0]     wr_data;
  logic                  commit;
  logic                  pwm_start;
  logic [DWIDTH-1:0]     pwm_data;
  logic                  boundary;
  logic                  busy;
  logic                  pending;
  logic [LOAD_CNT_W-1:0] load_count;

  modport master (
    output enable, wr_en, wr_addr, wr_data, commit,
    input  pwm_start, pwm_data, boundary, busy, pending, load_count
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data, commit,
    output pwm_start, pwm_data, boundary, busy, pending, load_count
  );

endinterface

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: free-running 0..PERIOD-1 counter, held at 0 while
// enable is low, with a one-cycle boundary pulse on the last count.
//   clk, rst  - clock, synchronous active-high reset
//   enable    - runs the counter
//   boundary  - enable && count == PERIOD-1
module pwm_period_timer #(
  parameter int PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic boundary
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] period_cnt;
  logic          at_end;

  assign at_end   = (period_cnt == CW'(PERIOD - 1));
  assign boundary = enable && at_end;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      period_cnt <= '0;
    end else if (at_end) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_load_sequencer.sv
// pwm_load_sequencer: owns the load port of a STAGE-channel PWM array.
// Host writes go to a shadow bank; a commit is applied at the next period
// boundary by snapshotting the bank and streaming it out as one burst of
// STAGE words, the first marked with pwm_start.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of pwm_load_sequencer_if (host write/commit port,
//              PWM start/data outputs, boundary/busy/pending/load_count)
module pwm_load_sequencer
  import pwm_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int STAGE  = DEF_STAGE,
  parameter int PERIOD = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  pwm_load_sequencer_if.slave  bus
);

  localparam int AW = (STAGE > 1) ? $clog2(STAGE) : 1;

  seq_state_t            state;
  logic [AW-1:0]         idx;
  logic [DWIDTH-1:0]     shadow   [STAGE];
  logic [DWIDTH-1:0]     snapshot [STAGE];
  logic                  pwm_start_q;
  logic [DWIDTH-1:0]     pwm_data_q;
  logic                  busy_q;
  logic                  pending_q;
  logic [LOAD_CNT_W-1:0] load_count_q;
  logic                  boundary;
  logic                  wr_ok;

  pwm_period_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (bus.enable),
    .boundary (boundary)
  );

  // Non-power-of-two STAGE leaves address codes that map to no channel.
  assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < 32'(STAGE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      shadow       <= '{default: '0};
      snapshot     <= '{default: '0};
      pwm_start_q  <= 1'b0;
      pwm_data_q   <= '0;
      busy_q       <= 1'b0;
      pending_q    <= 1'b0;
      load_count_q <= '0;
    end else begin
      if (wr_ok) begin
        shadow[bus.wr_addr] <= bus.wr_data;
      end
      unique case (state)
        IDLE: begin
          if (boundary && (pending_q || bus.commit)) begin
            snapshot    <= shadow;
            idx         <= '0;
            state       <= LOAD;
            pending_q   <= 1'b0;
            // Outputs are registered, so word 0 is taken straight from the
            // bank being snapshotted to appear in the first LOAD cycle.
            pwm_start_q <= 1'b1;
            pwm_data_q  <= shadow[0];
            busy_q      <= 1'b1;
          end else if (bus.commit) begin
            pending_q <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.commit) begin
            pending_q <= 1'b1;
          end
          pwm_start_q <= 1'b0;
          // idx is the word currently on pwm_data; preload the next one.
          if (idx == AW'(STAGE - 1)) begin
            state        <= IDLE;
            pwm_data_q   <= '0;
            busy_q       <= 1'b0;
            load_count_q <= load_count_q + 1'b1;
          end else begin
            idx        <= idx + 1'b1;
            pwm_data_q <= snapshot[idx + 1'b1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pwm_start  = pwm_start_q;
  assign bus.pwm_data   = pwm_data_q;
  assign bus.boundary   = boundary;
  assign bus.busy       = busy_q;
  assign bus.pending    = pending_q;
  assign bus.load_count = load_count_q;

endmodule
